pool_2d: RTL
============

# pool_2d

Streaming 2-D pooling unit. Reduces a raster-ordered single-channel feature map of IMG_W x IMG_H samples with non-overlapping POOL_K x POOL_K windows (stride = POOL_K), using max or, optionally, average. Supersedes the 1-D max-pool stage between the convolution datapath and the next layer's input buffer. Keeps the per-sample enable/bypass behaviour and adds window, geometry and mode generality.

## Interface
- DWIDTH, 20, signed sample width (two's complement)
- IMG_W, 8, feature-map columns; multiple of POOL_K
- IMG_H, 8, feature-map rows; multiple of POOL_K
- POOL_K, 2, window edge; power of two, 2..8
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- en_pool  in  1  1 = pool, 0 = bypass; sampled only at frame start
- mode  in  1  0 = max, 1 = average; sampled only at frame start; ignored without POOL_AVG_EN
- data_in  in  DWIDTH  input sample
- valid_in  in  1  data_in qualifier; no backpressure
- data_out  out  DWIDTH  pooled or bypassed sample
- valid_out  out  1  one-cycle qualifier per output
- frame_done  out  1  pulses with the last valid_out of a frame

## Operation
- Counters col (0..IMG_W-1), row (0..IMG_H-1), kx = col mod POOL_K, ky = row mod POOL_K. Counters advance only on valid_in. col wraps to 0 and increments row. row wraps to 0 at frame end.
- Active mode latch: en_pool and mode are captured into act_en/act_mode on a valid_in with col=0 and row=0. Changes mid-frame have no effect until the next frame.
- Bypass (act_en=0): data_out <= data_in and valid_out <= valid_in, registered. frame_done pulses on the output of sample IMG_W*IMG_H-1.
- Pool, horizontal: hacc is loaded at kx=0 and combined for kx>0 (max, or sum).
- Pool, vertical: at kx=POOL_K-1, the line-buffer entry col/POOL_K is written with hacc if ky=0, otherwise with combine(entry, hacc).
- Pool, output: at kx=POOL_K-1 and ky=POOL_K-1, the combined value is registered to data_out with valid_out=1.
- Output count: (IMG_W/POOL_K)*(IMG_H/POOL_K) outputs per frame, in raster order.
- Max: signed compare; on ties the earlier sample is kept (values are equal, so the result is unaffected).
- Average: the sum is carried at DWIDTH+2*log2(POOL_K) bits, then arithmetic right shift by 2*log2(POOL_K). This is a floor (toward negative infinity). The result always fits DWIDTH, so no saturation is needed.
- Line buffer: IMG_W/POOL_K entries of accumulator width. Contents are not cleared between rows, because ky=0 overwrites them.

## Timing
- Reset values: data_out=0, valid_out=0, frame_done=0, all counters 0, act_en=0, act_mode=0, hacc=0.
- Latency, bypass: 1 cycle.
- Latency, pool: 1 cycle after the window's last sample (bottom-right) is accepted.
- Throughput: one sample per cycle. Gaps in valid_in stall all state; outputs are identical to gap-free input.
- data_out holds its last value while valid_out=0.
- Reset asserted mid-frame: all state returns to reset values at once. The next valid_in is treated as pixel (0,0).
- Back-to-back frames need no idle cycle. The last pixel of frame n and pixel (0,0) of frame n+1 may arrive on consecutive cycles.
- Elaboration error if IMG_W or IMG_H is not a multiple of POOL_K, or if POOL_K is not a power of two.

## Configuration
- POOL_AVG_EN defined: average datapath is built and mode=1 selects it.
- POOL_AVG_EN undefined: no adder or shifter is built, the accumulator is DWIDTH bits, mode is ignored, and the block always pools with max.

## Structure
- Package pool_pkg holds:
  - the mode encoding constants (POOL_MAX=0, POOL_AVG=1)
  - a clog2 function
  - an accumulator-width function acc_w(DWIDTH, POOL_K)
- Sub-module pool_line_buf: IMG_W/POOL_K x acc_w storage, one synchronous write port, one combinational read port addressed by col/POOL_K.
- Top level holds the counters, mode latch, combine logic and output register.

## Test plan
- Max, IMG_W=IMG_H=4, POOL_K=2, en_pool=1, mode=0, input 0..15 raster -> outputs 5, 7, 13, 15 with valid_out; frame_done with 15.
- Average (POOL_AVG_EN), same stimulus, mode=1 -> outputs 2, 4, 10, 12.
- Negative window: 2x2 input -1, -2, -3, -4.
  - max -> -1
  - average -> -3 (floor of -2.5)
- Bypass: en_pool=0 at frame start, data_in=7 with valid_in=1 -> data_out=7 and valid_out=1 one cycle later.
  - Toggling en_pool mid-frame changes nothing until the next frame.
- valid_in gaps: the first test with two idle cycles after every sample -> the same four values in order, each one cycle after its window completes.
- Reset mid-frame: assert reset after sample 6, then resend 0..15 -> outputs 5, 7, 13, 15, with no stale partial results.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants and width helpers for the 2-D pooling unit.
// Accumulator width depends on whether POOL_AVG_EN is defined.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

`ifdef POOL_AVG_EN
    localparam int AVG_GROW = 1;
`else
    localparam int AVG_GROW = 0;
`endif

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A K x K sum needs 2*log2(K) guard bits; max-only keeps the sample width.
    function automatic int acc_w(input int dw, input int k);
        return dw + AVG_GROW * 2 * clog2(k);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Partial vertical results, one entry per output column.
// Synchronous write, combinational read.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    parameter int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // No reset: every entry is overwritten on the first row of each window band.
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_2d.sv
// Streaming non-overlapping K x K pooling (max; average when POOL_AVG_EN is defined).
// Raster-order input, no backpressure, per-frame enable/mode latch.
module pool_2d
    import pool_pkg::*;
#(
    parameter int DWIDTH = 20,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int POOL_K = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_pool,
    input  logic              mode,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              valid_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              valid_out,
    output logic              frame_done
);

    localparam int LK  = clog2(POOL_K);
    localparam int ACC = acc_w(DWIDTH, POOL_K);
    localparam int NE  = IMG_W / POOL_K;
    localparam int CW  = clog2(IMG_W);
    localparam int RW  = clog2(IMG_H);
    localparam int AW  = (clog2(NE) > 0) ? clog2(NE) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    generate
        if ((IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0 ||
            POOL_K < 2 || (POOL_K & (POOL_K - 1)) != 0) begin : g_cfg_err
            $error("pool_2d: IMG_W/IMG_H must be multiples of POOL_K, POOL_K a power of two");
        end
    endgenerate

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic                     r_act_en;
    logic signed [ACC-1:0]    r_hacc;
    logic [DWIDTH-1:0]        r_data_out;
    logic                     r_valid_out;
    logic                     r_frame_done;

    logic                     w_first;
    logic                     w_en;
    logic                     w_col_last;
    logic                     w_last;
    logic [LK-1:0]            w_kx;
    logic [LK-1:0]            w_ky;
    logic                     w_kx_last;
    logic                     w_ky_last;
    logic signed [ACC-1:0]    w_in;
    logic signed [ACC-1:0]    w_hsum;
    logic signed [ACC-1:0]    w_vsum;
    logic signed [ACC-1:0]    w_lb_rd;
    logic [AW-1:0]            w_lb_addr;
    logic                     w_lb_we;
    logic [DWIDTH-1:0]        w_res;

    // Pixel (0,0) must already see the new frame's settings, so bypass the latch there.
    assign w_first    = (r_col == '0) && (r_row == '0);
    assign w_en       = w_first ? en_pool : r_act_en;
    assign w_col_last = (r_col == COL_LAST);
    assign w_last     = w_col_last && (r_row == ROW_LAST);
    assign w_kx       = r_col[LK-1:0];
    assign w_ky       = r_row[LK-1:0];
    assign w_kx_last  = &w_kx;
    assign w_ky_last  = &w_ky;
    assign w_in       = ACC'(signed'(data_in));
    assign w_lb_addr  = AW'(r_col >> LK);
    assign w_lb_we    = valid_in && w_en && w_kx_last;

    function automatic logic signed [ACC-1:0] vmax(input logic signed [ACC-1:0] a,
                                                   input logic signed [ACC-1:0] b);
        return (b > a) ? b : a;
    endfunction

`ifdef POOL_AVG_EN
    logic r_act_mode;
    logic w_avg;
    assign w_avg = ((w_first ? mode : r_act_mode) == POOL_AVG);

    always_comb begin
        w_hsum = w_in;
        w_vsum = w_hsum;
        if (w_kx != '0) w_hsum = w_avg ? (r_hacc + w_in) : vmax(r_hacc, w_in);
        w_vsum = w_hsum;
        if (w_ky != '0) w_vsum = w_avg ? (w_lb_rd + w_hsum) : vmax(w_lb_rd, w_hsum);
    end

    // Taking the top DWIDTH bits is the arithmetic shift (floor) by 2*log2(K).
    assign w_res = w_avg ? w_vsum[ACC-1:2*LK] : w_vsum[DWIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    r_act_mode <= POOL_MAX;
        else if (valid_in && w_first) r_act_mode <= mode;
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    always_comb begin
        w_hsum = w_in;
        w_vsum = w_hsum;
        if (w_kx != '0) w_hsum = vmax(r_hacc, w_in);
        w_vsum = w_hsum;
        if (w_ky != '0) w_vsum = vmax(w_lb_rd, w_hsum);
    end

    assign w_res = w_vsum;
`endif

    pool_line_buf #(
        .DEPTH (NE),
        .WIDTH (ACC),
        .AW    (AW)
    ) u_lb (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_vsum),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_act_en     <= 1'b0;
            r_hacc       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_first) r_act_en <= en_pool;
                if (!w_en) begin
                    r_data_out   <= data_in;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= w_last;
                end else begin
                    r_hacc <= w_hsum;
                    if (w_kx_last && w_ky_last) begin
                        r_data_out   <= w_res;
                        r_valid_out  <= 1'b1;
                        r_frame_done <= w_last;
                    end
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule
